curve_contrast_ctrl: RTL and testbench

CURVE_CONTRAST_CTRL -- requirements
Module: curve_contrast_ctrl

---
 rtl/curve_pkg.sv | 43 ++++
 rtl/curve_contrast_lut.sv | 26 ++
 rtl/curve_contrast_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_curve_contrast_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/curve_pkg.sv
// Shared definitions for the curve contrast controller.
// Contents: curve index constants, mid-tone bounds, curve threshold, FSM state encoding,
// and an elaboration-time helper that computes one sigmoid curve entry.
package curve_pkg;

  // Curve indices: exponent E = 3 + 2 * index.
  localparam logic [1:0] SEL_E3 = 2'd0;
  localparam logic [1:0] SEL_E5 = 2'd1;
  localparam logic [1:0] SEL_E7 = 2'd2;
  localparam logic [1:0] SEL_E9 = 2'd3;

  localparam logic [7:0] THRESH = 8'd127;
  localparam logic [7:0] MID_LO = 8'd64;
  localparam logic [7:0] MID_HI = 8'd191;

  typedef enum logic [1:0] {
    StIdle,
    StFrame,
    StEval
  } state_e;

  // round(255 * x^e / (x^e + THRESH^e)); only ever evaluated on constants.
  function automatic logic [7:0] curve_val(input int unsigned e, input int unsigned x);
    logic [95:0] p;
    logic [95:0] q;
    logic [95:0] den;
    logic [95:0] num;
    logic [95:0] res;
    p = 96'd1;
    q = 96'd1;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < e) begin
        p = p * 96'(x);
        q = q * 96'(THRESH);
      end
    end
    den = p + q;
    num = (96'd510 * p) + den;
    res = num / (96'd2 * den);
    return res[7:0];
  endfunction

endpackage

// File: rtl/curve_contrast_lut.sv
// Combinational contrast curve lookup.
// Ports:
//   sel    - curve index (0..3 -> exponent 3/5/7/9, threshold 127)
//   Y      - input luma
//   curved - curved luma
module curve_contrast_lut
  import curve_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [7:0] Y,
  output logic [7:0] curved
);

  logic [7:0] lut_tbl [4][256];

  // Tables are folded to constants at elaboration; only the read mux remains.
  for (genvar s = 0; s < 4; s++) begin : g_sel
    for (genvar x = 0; x < 256; x++) begin : g_x
      localparam logic [7:0] Val = curve_val(3 + 2 * s, x);
      assign lut_tbl[s][x] = Val;
    end
  end

  assign curved = lut_tbl[sel][Y];

endmodule

// File: rtl/curve_contrast_ctrl.sv
// Frame-synchronous contrast curve controller.
// Applies one of four sigmoid curves to luma with a 2-cycle pipeline. Settings written through
// the cfg handshake take effect only at the next frame start. In auto mode, the curve for the
// next frame is chosen from the fraction of mid-tone pixels in the previous frame.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   cfg_valid/cfg_ready            - config handshake (ready low only during EVAL)
//   cfg_mode, cfg_bypass, cfg_sel  - auto/manual, bypass, manual curve index
//   per_frame_*, per_img_Y         - input sync and luma
//   post_frame_*, post_img_Y       - sync and curved luma, delayed 2 cycles
//   cur_sel                        - curve index in use this frame
module curve_contrast_ctrl
  import curve_pkg::*;
#(
  parameter int unsigned CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic       cfg_mode,
  input  logic       cfg_bypass,
  input  logic [1:0] cfg_sel,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_Y,
  output logic [1:0] cur_sel
);

  state_e           state_q;
  logic             vs_q;
  logic             armed_q;
  logic             ready_q;
  logic             pend_mode_q;
  logic             pend_byp_q;
  logic [1:0]       pend_sel_q;
  logic             act_byp_q;
  logic [1:0]       act_sel_q;
  logic [1:0]       auto_sel_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] mid_q;

  logic             s1_vs_q;
  logic             s1_hr_q;
  logic             s1_ce_q;
  logic [7:0]       s1_y_q;
  logic [7:0]       lut_y;

  logic             vs_rise;
  logic             vs_fall;
  logic             cfg_fire;
  logic             pix_en;
  logic             pix_mid;
  logic [CNT_W+1:0] mid_x4;
  logic [CNT_W+1:0] mid_x2;
  logic [CNT_W+1:0] tot_x1;
  logic [CNT_W+1:0] tot_x3;
  logic [1:0]       auto_d;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W - 1){1'b0}}, 1'b1};

  always_comb begin
    // armed_q blocks a false rise when reset is released in the middle of a frame.
    vs_rise  = per_frame_vsync & ~vs_q & armed_q;
    vs_fall  = ~per_frame_vsync & vs_q;
    cfg_fire = cfg_valid & ready_q;
    pix_en   = per_frame_href & per_frame_clken;
    pix_mid  = (per_img_Y >= MID_LO) && (per_img_Y <= MID_HI);
    mid_x4   = {mid_q, 2'b00};
    mid_x2   = {1'b0, mid_q, 1'b0};
    tot_x1   = {2'b00, total_q};
    tot_x3   = {1'b0, total_q, 1'b0} + {2'b00, total_q};
    if (mid_x4 >= tot_x3) begin
      auto_d = SEL_E9;
    end else if (mid_x2 >= tot_x1) begin
      auto_d = SEL_E7;
    end else if (mid_x4 >= tot_x1) begin
      auto_d = SEL_E5;
    end else begin
      auto_d = SEL_E3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      vs_q        <= 1'b0;
      armed_q     <= 1'b0;
      ready_q     <= 1'b1;
      pend_mode_q <= 1'b0;
      pend_byp_q  <= 1'b0;
      pend_sel_q  <= SEL_E5;
      act_byp_q   <= 1'b0;
      act_sel_q   <= SEL_E5;
      auto_sel_q  <= SEL_E5;
      total_q     <= '0;
      mid_q       <= '0;
    end else begin
      vs_q <= per_frame_vsync;
      if (!per_frame_vsync) begin
        armed_q <= 1'b1;
      end
      if (cfg_fire) begin
        pend_mode_q <= cfg_mode;
        pend_byp_q  <= cfg_bypass;
        pend_sel_q  <= cfg_sel;
      end
      // Uses the pending values from before any same-cycle write.
      if (vs_rise) begin
        act_byp_q <= pend_byp_q;
        act_sel_q <= pend_mode_q ? auto_sel_q : pend_sel_q;
      end
      unique case (state_q)
        StIdle: begin
          if (vs_rise) begin
            state_q <= StFrame;
            total_q <= '0;
            mid_q   <= '0;
          end
        end
        StFrame: begin
          if (vs_fall) begin
            state_q <= StEval;
            ready_q <= 1'b0;
          end else if (pix_en) begin
            if (total_q != CntMax) begin
              total_q <= total_q + CntOne;
            end
            if (pix_mid && (mid_q != CntMax)) begin
              mid_q <= mid_q + CntOne;
            end
          end
        end
        StEval: begin
          if (total_q != '0) begin
            auto_sel_q <= auto_d;
          end
          ready_q <= 1'b1;
          if (vs_rise) begin
            state_q <= StFrame;
            total_q <= '0;
            mid_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  curve_contrast_lut u_lut (
    .sel    (act_sel_q),
    .Y      (s1_y_q),
    .curved (lut_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vs_q          <= 1'b0;
      s1_hr_q          <= 1'b0;
      s1_ce_q          <= 1'b0;
      s1_y_q           <= 8'd0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Y       <= 8'd0;
    end else begin
      s1_vs_q          <= per_frame_vsync;
      s1_hr_q          <= per_frame_href;
      s1_ce_q          <= per_frame_clken;
      s1_y_q           <= per_img_Y;
      post_frame_vsync <= s1_vs_q;
      post_frame_href  <= s1_hr_q;
      post_frame_clken <= s1_ce_q;
      post_img_Y       <= act_byp_q ? s1_y_q : lut_y;
    end
  end

  assign cfg_ready = ready_q;
  assign cur_sel   = act_sel_q;

endmodule

// File: tb/tb_curve_contrast_ctrl.sv
module tb_curve_contrast_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic       cfg_mode = 1'b0;
  logic       cfg_bypass = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic       per_frame_vsync = 1'b0;
  logic       per_frame_href = 1'b0;
  logic       per_frame_clken = 1'b0;
  logic [7:0] per_img_Y = 8'd0;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic [7:0] post_img_Y;
  logic [1:0] cur_sel;

  int n_checks = 0;
  int n_fail = 0;
  int n_mon_print = 0;

  // Expected active settings of the current frame, set by hand per frame.
  logic [1:0] exp_sel = 2'd1;
  logic       exp_byp = 1'b0;

  // Scoreboard entry: {vsync, href, Y}.
  logic [9:0] exp_q[$];

  curve_contrast_ctrl #(.CNT_W(20)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_mode         (cfg_mode),
    .cfg_bypass       (cfg_bypass),
    .cfg_sel          (cfg_sel),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_Y        (per_img_Y),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_Y       (post_img_Y),
    .cur_sel          (cur_sel)
  );

  always #5 clk = ~clk;

  // Hand-computed round(255 / (1 + (127/x)^E)) for the luma values used here.
  function automatic logic [7:0] exp_lut(input logic [1:0] sel, input logic [7:0] y);
    logic [7:0] r;
    r = 8'd0;
    case (y)
      8'h00: r = 8'd0;
      8'h7F: r = 8'h80;
      8'h80: r = 8'd129 + {6'd0, sel};
      8'hFF: begin
        case (sel)
          2'd0: r = 8'd227;
          2'd1: r = 8'd247;
          2'd2: r = 8'd253;
          default: r = 8'd255;
        endcase
      end
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [7:0] y);
    logic [7:0] e;
    e = exp_byp ? y : exp_lut(exp_sel, y);
    exp_q.push_back({1'b1, 1'b1, e});
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    per_img_Y       = y;
    tick();
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
  endtask

  task automatic pixels(input int n, input logic [7:0] y);
    for (int i = 0; i < n; i++) pixel(y);
  endtask

  task automatic start_frame(input string name, input int exp_cur);
    per_frame_vsync = 1'b1;
    tick();
    chk(name, cur_sel, exp_cur);
  endtask

  task automatic drain();
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic end_frame(input bit expect_eval);
    drain();
    per_frame_vsync = 1'b0;
    tick();
    if (expect_eval) chk("eval_ready_low", cfg_ready, 0);
    else chk("no_eval_ready_high", cfg_ready, 1);
    tick();
    chk("ready_after_eval", cfg_ready, 1);
    tick();
  endtask

  task automatic cfg_write(input logic m, input logic b, input logic [1:0] s);
    bit done;
    done       = 1'b0;
    cfg_valid  = 1'b1;
    cfg_mode   = m;
    cfg_bypass = b;
    cfg_sel    = s;
    for (int i = 0; i < 20; i++) begin
      if (cfg_ready) begin
        tick();
        done = 1'b1;
        break;
      end
      tick();
    end
    cfg_valid = 1'b0;
    chk("cfg_accept", int'(done), 1);
  endtask

  // Monitor: every valid output pixel is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && post_frame_clken) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        if (n_mon_print < 30) begin
          n_mon_print++;
          $display("FAIL sb_unexpected: got Y=%0d with no pixel expected", post_img_Y);
        end
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({post_frame_vsync, post_frame_href, post_img_Y} !== e) begin
          n_fail++;
          if (n_mon_print < 30) begin
            n_mon_print++;
            $display("FAIL sb_pixel: got vs=%0b hr=%0b Y=%0d expected vs=%0b hr=%0b Y=%0d",
                     post_frame_vsync, post_frame_href, post_img_Y, e[9], e[8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    tick();
    chk("reset_post", int'({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y}), 0);
    chk("reset_cur_sel", cur_sel, 1);
    chk("reset_ready", cfg_ready, 1);
    rst_n = 1'b1;
    tick();
    tick();

    // A: reset settings (E5); manual write of sel 2 mid-frame must not apply yet
    exp_sel = 2'd1; exp_byp = 1'b0;
    start_frame("A_cur_sel", 1);
    pixel(8'h7F); pixel(8'hFF); pixel(8'h00);
    cfg_write(1'b0, 1'b0, 2'd2);
    chk("A_cur_sel_after_write", cur_sel, 1);
    end_frame(1'b1);

    // B: E7 now active; 0x7F -> 0x80. Request bypass for the next frame.
    exp_sel = 2'd2;
    start_frame("B_cur_sel", 2);
    pixel(8'h7F); pixel(8'hFF); pixel(8'h80);
    cfg_write(1'b0, 1'b1, 2'd2);
    end_frame(1'b1);

    // C: bypass, exact 2-cycle latency on data and sync
    exp_byp = 1'b1;
    start_frame("C_cur_sel", 2);
    pixel(8'h12);
    chk("C_lat_not_1", post_frame_clken, 0);
    tick();
    chk("C_lat_2", int'({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y}),
        int'({3'b111, 8'h12}));
    pixel(8'h34); pixel(8'hAB); pixel(8'hCD);
    cfg_write(1'b1, 1'b0, 2'd0);
    end_frame(1'b1);

    // D: auto mode; C had mid=1 of 4 -> E5. 80/100 mid -> next 3.
    exp_byp = 1'b0; exp_sel = 2'd1;
    start_frame("D_auto_cur_sel", 1);
    pixels(80, 8'h80);
    pixels(20, 8'h00);
    end_frame(1'b1);

    // E: 3; mid=25 of 100 -> next 1
    exp_sel = 2'd3;
    start_frame("E_auto_cur_sel", 3);
    pixels(25, 8'h80);
    pixels(75, 8'hFF);
    end_frame(1'b1);

    // F: 1; mid=24 of 100 -> next 0
    exp_sel = 2'd1;
    start_frame("F_auto_cur_sel", 1);
    pixels(24, 8'h80);
    pixels(76, 8'h00);
    end_frame(1'b1);

    // G: 0; empty frame keeps 0
    exp_sel = 2'd0;
    start_frame("G_auto_cur_sel", 0);
    end_frame(1'b1);

    // H: 0 kept; valid raised during EVAL is accepted the cycle after
    start_frame("H_empty_keeps", 0);
    pixel(8'h80); pixel(8'hFF);
    drain();
    per_frame_vsync = 1'b0;
    tick();
    chk("H_eval_ready_low", cfg_ready, 0);
    cfg_valid = 1'b1; cfg_mode = 1'b0; cfg_bypass = 1'b0; cfg_sel = 2'd3;
    tick();
    chk("H_ready_after_eval", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    tick();

    // I: held write applied; a write coincident with vsync rise waits a frame
    exp_sel = 2'd3;
    cfg_valid = 1'b1; cfg_mode = 1'b0; cfg_bypass = 1'b0; cfg_sel = 2'd0;
    chk("I_ready_at_rise", cfg_ready, 1);
    per_frame_vsync = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("I_cur_sel_coincident", cur_sel, 3);
    pixel(8'h7F); pixel(8'hFF);
    end_frame(1'b1);

    // J: coincident write now applied
    exp_sel = 2'd0;
    start_frame("J_cur_sel", 0);
    pixel(8'hFF); pixel(8'h80);
    end_frame(1'b1);

    // K: reset mid-frame -> outputs 0, reset settings, no EVAL at this frame's end
    start_frame("K_cur_sel", 0);
    pixel(8'h7F);
    drain();
    rst_n = 1'b0;
    tick();
    chk("K_reset_post", int'({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y}),
        0);
    chk("K_reset_cur_sel", cur_sel, 1);
    rst_n = 1'b1;
    exp_sel = 2'd1;
    pixel(8'hFF); pixel(8'h7F);
    end_frame(1'b0);

    // L: next frame starts normally with reset settings
    start_frame("L_cur_sel", 1);
    pixel(8'h80);
    end_frame(1'b1);

    tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
